// File: rtl/screen_pkg.sv
// Shared screen geometry and CPU access FSM state for the video RAM arbiter.
package screen_pkg;

   localparam int unsigned H_ACTIVE = 512;
   localparam int unsigned V_ACTIVE = 256;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 13;

   localparam int unsigned WORDS_PER_LINE = H_ACTIVE / DATA_W;
   localparam int unsigned IDX_W          = $clog2(DATA_W);

   typedef enum logic {
      IDLE,
      ACK
   } cpu_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU screen-port handshake and VRAM port bundled between requester, arbiter and RAM.
interface vram_arbiter_if;
   import screen_pkg::*;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );

   // CPU and RAM side.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/vram_pixel_serializer.sv
// Captures each fetched VRAM word and shifts it out as a registered 1-bit pixel stream.
module vram_pixel_serializer
   import screen_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_fetch,
   input  logic              active,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              pixel,
   output logic              pixel_valid
);

   logic              fetch_d1;
   logic              active_d1;
   logic [IDX_W-1:0]  idx_d1;
   logic [DATA_W-1:0] word_q;
   logic              pix_next;

   // The first pixel of a word comes straight off the RAM output, the rest from word_q.
   assign pix_next = fetch_d1 ? mem_rdata[0] : word_q[idx_d1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_d1    <= 1'b0;
         active_d1   <= 1'b0;
         idx_d1      <= '0;
         word_q      <= '0;
         pixel       <= 1'b0;
         pixel_valid <= 1'b0;
      end else begin
         fetch_d1    <= vid_fetch;
         active_d1   <= active;
         idx_d1      <= idx;
         if (fetch_d1) begin
            word_q <= mem_rdata;
         end
         pixel       <= active_d1 & pix_next;
         pixel_valid <= active_d1;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between raster scanout (every 16th active pixel) and the CPU.
module vram_arbiter
   import screen_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       hblank,
   input  logic       vblank,
   vram_arbiter_if.slave bus,
   output logic       pixel,
   output logic       pixel_valid
);

   logic              active;
   logic              vid_fetch;
   logic [ADDR_W-1:0] vid_addr;
   cpu_state_e        state_q, state_d;
   logic              we_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rd_ack;

   assign active    = !hblank && !vblank && (hpos < 10'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));
   assign vid_fetch = active && (hpos[IDX_W-1:0] == '0);
   assign vid_addr  = ADDR_W'(32'(vpos) * WORDS_PER_LINE + 32'(hpos) / DATA_W);

   always_comb begin
      state_d       = state_q;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = bus.cpu_wdata;
      bus.cpu_ack   = 1'b0;
      if (vid_fetch) begin
         bus.mem_addr = vid_addr;
      end
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req && !vid_fetch) begin
               bus.mem_we = bus.cpu_we;
               state_d    = ACK;
            end
         end
         ACK: begin
            bus.cpu_ack = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == ACK) begin
            we_q <= bus.cpu_we;
         end
      end
   end

   // Synchronous RAM: read data arrives during the ack cycle, so bypass it there and hold after.
   assign rd_ack        = (state_q == ACK) && !we_q;
   assign bus.cpu_rdata = rd_ack ? bus.mem_rdata : rdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (rd_ack) begin
         rdata_q <= bus.mem_rdata;
      end
   end

   vram_pixel_serializer u_serializer (
      .clk         (clk),
      .reset       (reset),
      .vid_fetch   (vid_fetch),
      .active      (active),
      .idx         (hpos[IDX_W-1:0]),
      .mem_rdata   (bus.mem_rdata),
      .pixel       (pixel),
      .pixel_valid (pixel_valid)
   );

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the single-port 8K x 16 video RAM between the CPU memory-mapped screen port and raster scanout.
- Every 16th active pixel cycle the scanout fetch takes the RAM. CPU reads and writes use all other cycles.
- The block serialises each fetched word into a registered 1-bit pixel stream.
- Sits between the CPU bus decode, the HV sync generator (same clock) and the VRAM instance.

Parameters:
- H_ACTIVE, 512, visible pixels per line.
- V_ACTIVE, 256, visible lines.
- DATA_W, 16, VRAM word width; pixels per word.
- ADDR_W, 13, VRAM word address width; must equal log2(H_ACTIVE*V_ACTIVE/DATA_W).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- hpos  in  10  current pixel column from the sync generator.
- vpos  in  10  current line from the sync generator.
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1, held afterwards.
- mem_addr  out  ADDR_W  VRAM address (combinational).
- mem_we  out  1  VRAM write enable (combinational).
- mem_wdata  out  DATA_W  VRAM write data (combinational).
- mem_rdata  in  DATA_W  VRAM read data; synchronous RAM, valid the cycle after the address.
- pixel  out  1  registered pixel value.
- pixel_valid  out  1  registered; 1 when pixel belongs to the active area.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values: cpu_ack=0, cpu_rdata=0, pixel=0, pixel_valid=0, FSM=IDLE, all pipeline registers 0.
- Active area: active = !hblank && !vblank && hpos<H_ACTIVE && vpos<V_ACTIVE.
- Video fetch condition: vid_fetch = active && hpos[3:0]==0.
- Video fetch address: vpos*(H_ACTIVE/DATA_W) + hpos/DATA_W. With defaults this is {vpos[7:0], hpos[8:4]}.
- Video fetch priority: vid_fetch owns the RAM unconditionally. mem_we=0 and mem_addr=video address.
- Pixel pipeline registers: fetch_d1 <= vid_fetch; active_d1 <= active; idx_d1 <= hpos[3:0]; word_q <= mem_rdata when fetch_d1.
- Pixel selection: pix_next = fetch_d1 ? mem_rdata[0] : word_q[idx_d1]. On the clock edge, pixel <= pix_next and pixel_valid <= active_d1.
- Pixel latency: the pixel for column x appears 2 cycles after hpos=x was presented. Bit 0 is the leftmost pixel of each word.
- Outside the active area: pixel=0, pixel_valid=0.
- CPU FSM, IDLE: if cpu_req && !vid_fetch, issue the access that cycle (mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata) and go to ACK. If cpu_req && vid_fetch, stay in IDLE and retry next cycle.
- CPU FSM, ACK: cpu_ack=1 for exactly this cycle. cpu_rdata <= mem_rdata on entry for reads; unchanged for writes. No CPU issue in this cycle. Next state is IDLE.
- CPU throughput and wait: at most one access per 2 cycles. Worst-case request-to-ack is 3 cycles (one stall, because vid_fetch never occurs on consecutive cycles).
- Idle defaults: mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- Address wrap: CPU addresses are full-range with no decoding. The video address never exceeds H_ACTIVE*V_ACTIVE/DATA_W-1.
- Simultaneous cpu_req and vid_fetch: the video fetch wins. The CPU is never granted in a vid_fetch cycle.
- Reset mid-access: FSM returns to IDLE and no ack is issued. A write already issued has completed in RAM. The requester re-presents its request after reset.
- cpu_req dropping without an ack is illegal; behaviour is not defined.

Decomposition:
- Shared package (screen_pkg): H_ACTIVE, V_ACTIVE, DATA_W, ADDR_W, and the CPU FSM state enum {IDLE, ACK}.
- One natural sub-module: vram_pixel_serializer. It contains the fetch_d1/idx_d1/word_q pipeline and the pixel/pixel_valid registers.
- Arbitration and the FSM stay in the top module.

Test Plan:
- CPU write 0xA5A5 to address 0x0123 with no video activity (vblank=1) -> mem_we=1 in the issue cycle; cpu_ack 1 cycle later.
- CPU read of address 0x0123 -> cpu_ack with cpu_rdata=0xA5A5, held after the ack.
- cpu_req asserted in the cycle hpos=16, vpos=0, active -> mem_addr=0x0001 with mem_we=0 that cycle; CPU issued next cycle; ack at +2; worst case 3 cycles confirmed.
- VRAM[0]=0x0005, VRAM[1]=0x8000, scan line 0 -> pixel_valid rises 2 cycles after hpos=0. Pixels for x=0..2 are 1,0,1; x=31 is 1; all others 0.
- Line vpos=255, hpos=496 -> fetch address 0x1FFF. At hpos=512 (blank), pixel_valid=0 two cycles later, and no fetch occurs during blanking.
- Reset asserted in ACK state, and mid-line -> cpu_ack=0, pixel=0, pixel_valid=0 immediately. After release, the first fetch occurs at the next active hpos[3:0]==0.
